sprite_renderer: RTL and testbench
==================================

# sprite_renderer

Consumes the `sprite_x`/`sprite_y` position produced by the sprite movement logic and turns it, together with a serially loaded 1-bpp bitmap, into a per-pixel sprite on/off stream for the low-resolution raster. Sits between the movement block and the final colour mux. Position is latched once per frame, and the bitmap is double-buffered, so neither can tear mid-frame.

## Interface
- `SPRITE_WIDTH`, default 12: sprite width in small pixels, 1..16.
- `SPRITE_HEIGHT`, default 12: sprite height in small pixels, 1..16.
- `WIDTH_SMALL`, default 160: raster width in small pixels, ≤256.
- `HEIGHT_SMALL`, default 120: raster height in small pixels, ≤256.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `next_frame` in 1: one-cycle frame-start strobe, same strobe the movement block uses.
- `sprite_x` in 8: sprite left column from the movement block.
- `sprite_y` in 8: sprite top row from the movement block.
- `pos_valid` in 1: `pos_x`/`pos_y` are a visible pixel this cycle.
- `pos_x` in 8: current raster column, 0..WIDTH_SMALL-1.
- `pos_y` in 8: current raster row, 0..HEIGHT_SMALL-1.
- `load_start` in 1: begin a new bitmap load and clear the load counter.
- `load_en` in 1: `load_bit` is valid this cycle.
- `load_bit` in 1: bitmap bit, row-major, row 0 first, leftmost pixel first.
- `pixel_valid` out 1: `pos_valid` delayed by 2 cycles.
- `pixel_out` out 1: sprite pixel set at the position presented 2 cycles earlier.
- `load_busy` out 1: high while a load is in progress but not yet complete.

## Operation
- Reset values:
  - Outputs: `pixel_out`=0, `pixel_valid`=0, `load_busy`=0.
  - Internal state: latched position 0,0; active and shadow bitmaps all-zero, so the sprite is invisible; load FSM in IDLE; load counter 0.
- Position latch: on `next_frame`, capture `sprite_x`/`sprite_y` into `sx_l`/`sy_l`. Rendering uses only the latched values.
- Load FSM, states IDLE, LOADING, FULL:
  - IDLE→LOADING on `load_start`.
  - LOADING: each `load_en` writes `load_bit` into shadow bit `cnt` (index = row*SPRITE_WIDTH+col), then `cnt`++.
  - At `cnt`=N-1 with `load_en` high, go to FULL. N = SPRITE_WIDTH*SPRITE_HEIGHT.
  - FULL: on `next_frame`, copy shadow→active and go to IDLE.
  - `load_start` in any state restarts: go to LOADING with `cnt`=0. An aborted or partial load never reaches active.
  - `load_start` and `load_en` in the same cycle: that bit is stored as bit 0 and `cnt` becomes 1.
  - `load_en` in IDLE or FULL is ignored.
  - `load_busy` = (state==LOADING), registered.
- Hit test, stage 1 (registered):
  - dx = {1'b0,`pos_x`} − {1'b0,`sx_l`} and dy likewise, both 9-bit.
  - in = `pos_valid` & ~dx[8] & ~dy[8] & dx<SPRITE_WIDTH & dy<SPRITE_HEIGHT.
  - Register in, dx[3:0], dy[3:0], and `pos_valid`.
- Stage 2 (registered): `pixel_out` = in & active[dy*SPRITE_WIDTH+dx]. `pixel_out` is 0 whenever not in.
- Clipping: a sprite extending past the right or bottom edge is clipped naturally, because `pos_x`/`pos_y` never exceed the raster. There is no wrap-around: `pos_x` < `sx_l` is a miss, not a wrap.

## Timing
- Latency from `pos_*` to `pixel_out`/`pixel_valid`: exactly 2 cycles, fully pipelined at one pixel per cycle.
- A `next_frame` in cycle t affects hit tests for positions presented in cycle t+1 onward. A position presented in cycle t uses the old latch.
- Final `load_en` (FULL entered at t+1) in the same cycle as `next_frame` at t: no commit. Commit happens on the following `next_frame`.
- Commit on `next_frame` at t: positions presented from t+1 use the new bitmap.
- Reset asserted mid-load or mid-frame: all state returns to reset values immediately. The shadow contents are discarded.

## Structure
- Package `sprite_pkg`: `load_state_t` enum (IDLE, LOADING, FULL); default sprite/raster dimension localparams shared with the movement block.
- One sub-module, `sprite_bitmap`:
  - Shadow and active registers, load FSM and counter.
  - Combinational read port (dx, dy) → bit.
- The top level holds the position latch and the 2-stage hit pipeline.

## Test plan
- Reset, then sweep the full raster with `pos_valid`=1 → `pixel_out`=0 everywhere, `pixel_valid` tracks `pos_valid` with 2-cycle delay.
- Load all-ones, then `next_frame` with `sprite_x`=10, `sprite_y`=5 → `pixel_out`=1 exactly for x 10..21, y 5..16; 0 at (9,5), (22,5), (10,17).
- Load a checkerboard (bit 0 = 1), commit, place at (0,0) → `pixel_out`(0,0)=1, (1,0)=0, (0,1)=0; `load_busy` high for exactly N `load_en` cycles.
- Place at `sprite_x`=150 with all-ones loaded → columns 150..159 are 1; no pixels at x 0..1 (no wrap).
- Restart with `load_start` after 50 bits, then load a full new pattern → only the new pattern is visible after `next_frame`. Final bit coincident with `next_frame` → the old bitmap stays until the next frame.
- Change `sprite_x` mid-frame without `next_frame` → output unchanged. Assert `reset_n` mid-load → `load_busy`=0 and the sprite is invisible.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and default dimensions for the sprite path (movement + renderer).
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } load_state_t;

    localparam int SPRITE_WIDTH_DEF  = 12;
    localparam int SPRITE_HEIGHT_DEF = 12;
    localparam int WIDTH_SMALL_DEF   = 160;
    localparam int HEIGHT_SMALL_DEF  = 120;

endpackage

// File: rtl/sprite_bitmap.sv
// Double-buffered 1-bpp sprite bitmap: serial loader into a shadow copy,
// committed to the active copy on a frame boundary, with a combinational read port.
module sprite_bitmap
    import sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = SPRITE_WIDTH_DEF,
    parameter int SPRITE_HEIGHT = SPRITE_HEIGHT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       next_frame,
    input  logic       load_start,
    input  logic       load_en,
    input  logic       load_bit,
    input  logic [3:0] rd_dx,
    input  logic [3:0] rd_dy,
    output logic       rd_bit,
    output logic       load_busy
);

    localparam int         N     = SPRITE_WIDTH * SPRITE_HEIGHT;
    localparam int         IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [8:0] LAST  = 9'(N - 1);
    localparam logic [8:0] NUM   = 9'(N);
    localparam logic [8:0] SW9   = 9'(SPRITE_WIDTH);

    load_state_t      state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             commit;
    logic [N-1:0]     shadow_q;
    logic [N-1:0]     active_q;
    logic [8:0]       rd_idx;

    // Load FSM next state: load_start restarts from any state, a coincident
    // load_en stores its bit at index 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q[IDX_W-1:0];
        commit  = 1'b0;
        if (load_start) begin
            wr_idx  = '0;
            wr_en   = load_en;
            cnt_d   = load_en ? 9'd1 : 9'd0;
            state_d = (load_en && N == 1) ? FULL : LOADING;
        end else begin
            case (state_q)
                LOADING: begin
                    if (load_en) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 9'd1;
                        if (cnt_q == LAST) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (next_frame) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load FSM state, counter and registered busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            load_busy <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_busy <= (state_d == LOADING);
        end
    end

    // Shadow fills serially; only a complete load is ever copied to active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_en) begin
                shadow_q[wr_idx] <= load_bit;
            end
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    // Row-major read; offsets beyond the bitmap read as transparent.
    always_comb begin
        rd_idx = {5'd0, rd_dy} * SW9 + {5'd0, rd_dx};
        rd_bit = (rd_idx < NUM) ? active_q[rd_idx[IDX_W-1:0]] : 1'b0;
    end

endmodule

// File: rtl/sprite_renderer.sv
// Per-pixel sprite on/off stream: frame-latched position, 2-stage hit pipeline,
// double-buffered bitmap.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = SPRITE_WIDTH_DEF,
    parameter int SPRITE_HEIGHT = SPRITE_HEIGHT_DEF,
    parameter int WIDTH_SMALL   = WIDTH_SMALL_DEF,
    parameter int HEIGHT_SMALL  = HEIGHT_SMALL_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       next_frame,
    input  logic [7:0] sprite_x,
    input  logic [7:0] sprite_y,
    input  logic       pos_valid,
    input  logic [7:0] pos_x,
    input  logic [7:0] pos_y,
    input  logic       load_start,
    input  logic       load_en,
    input  logic       load_bit,
    output logic       pixel_valid,
    output logic       pixel_out,
    output logic       load_busy
);

    localparam logic [8:0] SW9 = 9'(SPRITE_WIDTH);
    localparam logic [8:0] SH9 = 9'(SPRITE_HEIGHT);
    localparam logic [8:0] RW9 = 9'(WIDTH_SMALL);
    localparam logic [8:0] RH9 = 9'(HEIGHT_SMALL);

    logic [7:0] sx_l, sy_l;
    logic [8:0] dx, dy;
    logic       in_p0;
    logic       in_p1, vld_p1;
    logic [3:0] dx_p1, dy_p1;
    logic       rd_bit;

    // Position is sampled once per frame so the sprite cannot tear mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_l <= '0;
            sy_l <= '0;
        end else if (next_frame) begin
            sx_l <= sprite_x;
            sy_l <= sprite_y;
        end
    end

    // Hit test: a negative offset (borrow in bit 8) is a miss, never a wrap.
    always_comb begin
        dx    = {1'b0, pos_x} - {1'b0, sx_l};
        dy    = {1'b0, pos_y} - {1'b0, sy_l};
        in_p0 = pos_valid & ~dx[8] & ~dy[8] & (dx < SW9) & (dy < SH9)
              & ({1'b0, pos_x} < RW9) & ({1'b0, pos_y} < RH9);
    end

    // ---- stage 1: hit flag and sprite-relative offsets ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_p1  <= 1'b0;
            vld_p1 <= 1'b0;
            dx_p1  <= '0;
            dy_p1  <= '0;
        end else begin
            in_p1  <= in_p0;
            vld_p1 <= pos_valid;
            dx_p1  <= dx[3:0];
            dy_p1  <= dy[3:0];
        end
    end

    sprite_bitmap #(
        .SPRITE_WIDTH  (SPRITE_WIDTH),
        .SPRITE_HEIGHT (SPRITE_HEIGHT)
    ) u_bitmap (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_frame (next_frame),
        .load_start (load_start),
        .load_en    (load_en),
        .load_bit   (load_bit),
        .rd_dx      (dx_p1),
        .rd_dy      (dy_p1),
        .rd_bit     (rd_bit),
        .load_busy  (load_busy)
    );

    // ---- stage 2: bitmap lookup, forced to 0 outside the sprite ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_out   <= in_p1 & rd_bit;
            pixel_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: behavioural model feeding a
// 2-cycle scoreboard queue, plus a table of hand-derived pixel vectors.
module tb_sprite_renderer;

    localparam int W = 12;
    localparam int H = 12;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       next_frame = 1'b0;
    logic [7:0] sprite_x = '0, sprite_y = '0;
    logic       pos_valid = 1'b0;
    logic [7:0] pos_x = '0, pos_y = '0;
    logic       load_start = 1'b0, load_en = 1'b0, load_bit = 1'b0;
    logic       pixel_valid, pixel_out, load_busy;

    sprite_renderer #(
        .SPRITE_WIDTH  (W),
        .SPRITE_HEIGHT (H),
        .WIDTH_SMALL   (160),
        .HEIGHT_SMALL  (120)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .next_frame  (next_frame),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .load_start  (load_start),
        .load_en     (load_en),
        .load_bit    (load_bit),
        .pixel_valid (pixel_valid),
        .pixel_out   (pixel_out),
        .load_busy   (load_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic p; } exp_t;
    typedef struct { int g; int x; int y; logic e; } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model state
    int   m_sx, m_sy, m_state, m_cnt;
    logic m_shadow[N];
    logic m_active[N];

    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return ((i / W + i % W) % 2) == 0;
            2:       return (i % 3) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void add(input int g, input int x, input int y, input logic e);
        vec_t v;
        v.g = g; v.x = x; v.y = y; v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_state = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 1'b0;
            m_active[i] = 1'b0;
        end
    endtask

    // Model of the state change at the coming clock edge.
    task automatic model_edge();
        if (next_frame) begin
            m_sx = int'(sprite_x);
            m_sy = int'(sprite_y);
        end
        if (load_start) begin
            m_state = 1;
            m_cnt   = 0;
            if (load_en) begin
                m_shadow[0] = load_bit;
                m_cnt = 1;
            end
        end else if (m_state == 1 && load_en) begin
            m_shadow[m_cnt] = load_bit;
            if (m_cnt == N - 1) m_state = 2;
            m_cnt++;
        end else if (m_state == 2 && next_frame) begin
            for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
            m_state = 0;
        end
    endtask

    // One clock: push expectation, clock, compare the output due now.
    task automatic cycle(input bit use_tbl, input logic tbl_pix);
        exp_t e, got;
        int   dx, dy;
        bit   hit;
        dx  = int'(pos_x) - m_sx;
        dy  = int'(pos_y) - m_sy;
        hit = pos_valid && dx >= 0 && dy >= 0 && dx < W && dy < H;
        model_edge();
        e.v = pos_valid;
        if (use_tbl) e.p = tbl_pix;
        else         e.p = hit ? m_active[dy * W + dx] : 1'b0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        next_frame = 1'b0;
        load_start = 1'b0;
        load_en    = 1'b0;
        got = sbq.pop_front();
        n_vec++;
        if ({pixel_valid, pixel_out, load_busy} !== {got.v, got.p, (m_state == 1)}) begin
            n_bad++;
            $display("FAIL pix t=%0t: got valid/pix/busy=%b%b%b expected %b%b%b",
                     $time, pixel_valid, pixel_out, load_busy, got.v, got.p, (m_state == 1));
        end
    endtask

    task automatic do_reset();
        exp_t e0;
        reset_n = 1'b0;
        next_frame = 1'b0; load_start = 1'b0; load_en = 1'b0; pos_valid = 1'b0;
        #2;
        chk("rst_pixel_out", int'(pixel_out), 0);
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_load_busy", int'(load_busy), 0);
        model_reset();
        sbq.delete();
        e0.v = 1'b0; e0.p = 1'b0;
        sbq.push_back(e0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load(input int kind, input int nbits, input bit nf_last, output int busy_cnt);
        busy_cnt   = 0;
        pos_valid  = 1'b0;
        load_start = 1'b1;
        cycle(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (load_busy) busy_cnt++;
            load_en  = 1'b1;
            load_bit = pat(kind, i);
            if (nf_last && i == nbits - 1) next_frame = 1'b1;
            cycle(1'b0, 1'b0);
        end
        if (load_busy) busy_cnt++;
    endtask

    task automatic frame(input int sx, input int sy);
        sprite_x   = 8'(sx);
        sprite_y   = 8'(sy);
        next_frame = 1'b1;
        pos_valid  = 1'b0;
        cycle(1'b0, 1'b0);
    endtask

    task automatic sweep(input int x0, input int x1, input int y0, input int y1, input bit gaps);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                pos_x     = 8'(x);
                pos_y     = 8'(y);
                pos_valid = !(gaps && (x % 7) == 3);
                cycle(1'b0, 1'b0);
            end
        end
        pos_valid = 1'b0;
    endtask

    task automatic apply_group(input int g);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].g == g) begin
                pos_x     = 8'(tbl[i].x);
                pos_y     = 8'(tbl[i].y);
                pos_valid = 1'b1;
                cycle(1'b1, tbl[i].e);
            end
        end
        pos_valid = 1'b0;
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;

        // all-ones sprite at (10,5)
        add(2, 10, 5, 1); add(2, 21, 5, 1); add(2, 10, 16, 1); add(2, 21, 16, 1);
        add(2, 9, 5, 0);  add(2, 22, 5, 0); add(2, 10, 17, 0); add(2, 10, 4, 0);
        // checkerboard at (0,0)
        add(3, 0, 0, 1); add(3, 1, 0, 0); add(3, 0, 1, 0); add(3, 1, 1, 1);
        // all-ones at (150,5), right-edge clip, no wrap
        add(4, 150, 5, 1); add(4, 159, 5, 1); add(4, 149, 5, 0); add(4, 0, 5, 0);
        add(4, 1, 5, 0);   add(4, 159, 16, 1); add(4, 159, 17, 0);
        // every-third-bit pattern at (20,20)
        add(5, 20, 20, 1); add(5, 21, 20, 0); add(5, 23, 20, 1); add(5, 20, 21, 1);
        // checker load ended with next_frame: old pattern still shown
        add(6, 20, 21, 1); add(6, 21, 21, 0);
        // following frame: checkerboard shown
        add(7, 20, 21, 0); add(7, 21, 21, 1); add(7, 20, 20, 1);
        // sprite_x/y changed without next_frame
        add(8, 20, 20, 1); add(8, 100, 100, 0);
        // after mid-load reset
        add(9, 0, 0, 0); add(9, 20, 20, 0);

        do_reset();
        sweep(0, 159, 0, 119, 1'b1);

        load(0, N, 1'b0, busy);
        chk("busy_ones", busy, N);
        frame(10, 5);
        apply_group(2);
        sweep(0, 31, 0, 20, 1'b0);

        load(1, N, 1'b0, busy);
        chk("busy_checker", busy, N);
        frame(0, 0);
        apply_group(3);
        sweep(0, 15, 0, 15, 1'b0);

        load(0, N, 1'b0, busy);
        frame(150, 5);
        apply_group(4);
        sweep(145, 159, 0, 20, 1'b0);
        sweep(0, 3, 0, 20, 1'b0);

        load(0, 50, 1'b0, busy);
        frame(20, 20);
        load(2, N, 1'b0, busy);
        chk("busy_restart", busy, N);
        frame(20, 20);
        apply_group(5);
        sweep(18, 35, 18, 35, 1'b0);

        load(1, N, 1'b1, busy);
        apply_group(6);
        frame(20, 20);
        apply_group(7);

        sprite_x = 8'd100;
        sprite_y = 8'd100;
        apply_group(8);
        sweep(18, 35, 18, 35, 1'b0);

        load(3, 30, 1'b0, busy);
        do_reset();
        apply_group(9);
        sweep(0, 23, 0, 23, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
